regfile_commit: RTL
===================

Name: regfile_commit

Overview:
- Architectural integer register file and commit point at the sink end of the writeback interface.
- Consumes the writeback stage's per-cycle retire bundle: valid, pc, write enable, write address, write data, break flag.
- Provides two combinational read ports to the decode stage.
- Tracks retired-instruction count and last-commit info for the difftest harness; enters a halt state on a break commit.

Parameters:
- XLEN, 32, data width of registers, write data and PCs.
- NREG, 32, number of registers; address width is log2(NREG) (5 at default).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  retire bundle valid this cycle.
- wb_pc  input  XLEN  PC of the retiring instruction.
- wb_rf_we  input  1  register write enable.
- wb_rf_waddr  input  5  destination register.
- wb_rf_wdata  input  XLEN  write data.
- wb_is_break  input  1  retiring instruction is ebreak.
- raddr1  input  5  read port 1 address.
- rdata1  output  XLEN  read port 1 data.
- raddr2  input  5  read port 2 address.
- rdata2  output  XLEN  read port 2 data.
- commit_valid  output  1  registered: an instruction retired last cycle.
- commit_pc  output  XLEN  registered: PC of that instruction.
- commit_cnt  output  CNT_W  number of accepted commits.
- halted  output  1  core halted by ebreak.
- halt_pc  output  XLEN  PC of the ebreak.
- halt_code  output  XLEN  value of x10 (a0) at halt.

Behaviour:
- Reset (async, active-high, effective immediately):
  - all registers, commit_valid, commit_pc, commit_cnt, halted, halt_pc and halt_code go to 0.
  - State goes to RUN.
- Accept condition: accept = wb_valid && state==RUN. This block is always ready; there is no back-pressure toward the writeback stage.
- Register write: on a rising edge with accept && wb_rf_we && wb_rf_waddr!=0, reg[waddr] <= wdata.
  - Writes to x0 are discarded; x0 always reads 0.
- Read ports are combinational with same-cycle bypass:
  - if raddr==0, rdata=0.
  - else if accept && wb_rf_we && wb_rf_waddr==raddr, rdata=wb_rf_wdata.
  - else rdata=reg[raddr].
  - Both ports are independent; they may read the same address.
- Commit tracking: on every edge, commit_valid <= accept and commit_pc <= accept ? wb_pc : commit_pc.
  - commit_cnt increments by 1 per accept and wraps modulo 2^CNT_W.
  - Latency: one cycle from the input bundle to commit_valid, commit_pc and commit_cnt.
- State machine has two states, RUN and HALT.
  - RUN -> HALT on accept && wb_is_break. halted=1 from the next cycle on.
  - At that edge: halt_pc <= wb_pc; halt_code <= x10 after applying that same commit's write (if the break bundle writes x10, the new data is used).
  - The breaking commit is itself committed: it is counted, raises commit_valid, and performs its write if wb_rf_we.
  - HALT -> RUN only on reset. In HALT all bundles are ignored: no writes, no count, commit_valid=0, no bypass. Reads still return stored values.
- Simultaneous write and read of the same register returns the new data via the bypass; the stored copy updates at the edge.
- Reset asserted mid-run clears the whole file; a bundle present during reset is dropped.

Test Plan:
- Basic write/read: commit x5=0xDEADBEEF at pc 0x80000000, then read raddr1=5 -> rdata1=0xDEADBEEF. commit_valid=1 and commit_pc=0x80000000 one cycle later; commit_cnt=1.
- x0 protection: commit x0=0x12345678 with we=1 -> rdata1 with raddr1=0 stays 0. commit_cnt still increments.
- Bypass: commit x7=0x55 while raddr1=raddr2=7 in the same cycle -> both read 0x55 combinationally. The previous x7 value is not visible.
- Invalid/no-write: wb_valid=0 with we=1, x3=0x99 -> x3 unchanged, commit_valid=0, count unchanged.
- Halt: x10=0, then an ebreak bundle at pc 0x80000010 writing x10=0x0 vs. a variant writing x10=0x1 -> halted=1, halt_pc=0x80000010, halt_code=0 or 1 respectively. A later commit of x6=0x77 is ignored: x6 unchanged, count frozen, commit_valid=0.
- Async reset mid-run: after 3 commits, assert reset between edges -> all outputs and registers are 0 immediately. After release, state is RUN and the first commit gives commit_cnt=1.

Source files
------------

// File: rtl/regfile_commit.sv
`default_nettype none
// ============================================================================
// Module   : regfile_commit
// Purpose  : Architectural integer register file and commit point at the sink
//            end of the writeback interface. Accepts one retire bundle per
//            cycle, provides two combinational read ports with same-cycle
//            bypass, and tracks commit info for the difftest harness. A
//            committed ebreak halts the core until reset.
// Ports    : clock, reset (async, active-high)
//            wb_*            retire bundle from writeback (always accepted
//                            while running, no back-pressure)
//            raddr1/rdata1,
//            raddr2/rdata2   combinational read ports to decode
//            commit_valid/commit_pc/commit_cnt   registered commit info
//            halted/halt_pc/halt_code            halt status (a0 at ebreak)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_commit #(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int CNT_W = 64,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic            wb_rf_we,
  input  logic [AW-1:0]   wb_rf_waddr,
  input  logic [XLEN-1:0] wb_rf_wdata,
  input  logic            wb_is_break,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [CNT_W-1:0] commit_cnt,
  output logic            halted,
  output logic [XLEN-1:0] halt_pc,
  output logic [XLEN-1:0] halt_code
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [AW-1:0]    A0_IDX  = AW'(10);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [XLEN-1:0]  regs_q [NREG];
  logic             commit_valid_q;
  logic [XLEN-1:0]  commit_pc_q;
  logic [CNT_W-1:0] commit_cnt_q;
  logic [XLEN-1:0]  halt_pc_q;
  logic [XLEN-1:0]  halt_code_q;

  logic             accept;
  logic             wr_en;
  logic [XLEN-1:0]  a0_next;

  // Bundles are only consumed while running; in HALT everything is dropped,
  // which also disables the bypass path.
  assign accept = wb_valid && (state_q == RUN);
  assign wr_en  = accept && wb_rf_we && (wb_rf_waddr != '0);

  // a0 as it will be after this cycle's commit, so an ebreak that writes
  // x10 reports its own result.
  assign a0_next = (wr_en && (wb_rf_waddr == A0_IDX)) ? wb_rf_wdata : regs_q[A0_IDX];

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && wb_is_break) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register file and commit tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_cnt_q   <= '0;
      halt_pc_q      <= '0;
      halt_code_q    <= '0;
    end else begin
      if (wr_en) begin
        regs_q[wb_rf_waddr] <= wb_rf_wdata;
      end
      commit_valid_q <= accept;
      if (accept) begin
        commit_pc_q  <= wb_pc;
        commit_cnt_q <= commit_cnt_q + CNT_ONE;
      end
      if (accept && wb_is_break) begin
        halt_pc_q   <= wb_pc;
        halt_code_q <= a0_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: x0 is hard zero, then bypass of the in-flight write.
  // --------------------------------------------------------------------------
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wr_en && (wb_rf_waddr == raddr1)) begin
      rdata1 = wb_rf_wdata;
    end
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wr_en && (wb_rf_waddr == raddr2)) begin
      rdata2 = wb_rf_wdata;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign commit_cnt   = commit_cnt_q;
  assign halted       = (state_q == HALT);
  assign halt_pc      = halt_pc_q;
  assign halt_code    = halt_code_q;

endmodule
`default_nettype wire
